// File: rtl/si53xx_spi_responder.sv
// Purpose : SPI mode-0 slave modelling the Si53xx register interface (256 x 8 register file, write strobe).
// Latency : pin edge -> internal event after SYNC_STAGES+1 clk; reg_wr one clk after the completing sclk rise.
// Backpres: none; the SPI master owns timing, and sclk must be at least 8 clk periods.
// Ports   : clk/reset (sync, active low); nCS/sclk/sdi from master; sdo/sdo_oe read data back;
//           reg_wr/reg_addr/reg_wdata write report; busy = synchronized nCS low; frame_err = abort/illegal pulse.
module si53xx_spi_responder #(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] REG_INIT    = 8'h00
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       nCS,
   input  logic       sclk,
   input  logic       sdi,
   output logic       sdo,
   output logic       sdo_oe,
   output logic       reg_wr,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       busy,
   output logic       frame_err
);

   localparam logic [2:0] CMD_SET_ADDR  = 3'b000;
   localparam logic [2:0] CMD_WRITE     = 3'b010;
   localparam logic [2:0] CMD_READ      = 3'b100;
   localparam logic [2:0] CMD_WRITE_INC = 3'b011;
   localparam logic [2:0] CMD_READ_INC  = 3'b101;
   localparam logic [2:0] CMD_BURST     = 3'b111;

   typedef enum logic [2:0] {S_IDLE, S_CMD, S_ARG, S_BURST, S_IGNORE} state_t;

   // Synchronizers run freely through reset so that no false edge is seen
   // when reset releases in the middle of a frame.
   logic [SYNC_STAGES-1:0] ncs_sync, sclk_sync, sdi_sync;
   logic                   ncs_prev, sclk_prev;

   always_ff @(posedge clk) begin
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], nCS};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], sdi};
      ncs_prev  <= ncs_sync[SYNC_STAGES-1];
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
   end

   logic ncs_s, sclk_s, sdi_s;
   logic ncs_fall, ncs_rise, sclk_rise, sclk_fall;
   assign ncs_s     = ncs_sync[SYNC_STAGES-1];
   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign sdi_s     = sdi_sync[SYNC_STAGES-1];
   assign ncs_fall  = ~ncs_s & ncs_prev;
   assign ncs_rise  = ncs_s & ~ncs_prev;
   assign sclk_rise = sclk_s & ~sclk_prev;
   assign sclk_fall = ~sclk_s & sclk_prev;

   state_t     state;
   logic [2:0] cmd;
   logic [2:0] bit_cnt;
   logic [6:0] rx_shift;
   logic [7:0] ptr;
   logic       have_addr;   // burst: address byte already taken
   logic       rd_arm;      // load tx_shift on the next sclk fall
   logic [6:0] tx_shift;    // bit 7 already sits in sdo once loaded
   logic [2:0] tx_cnt;
   logic [7:0] regs [256];

   logic [7:0] rx_byte;
   logic       byte_done;
   assign rx_byte   = {rx_shift, sdi_s};
   assign byte_done = (bit_cnt == 3'd7);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= S_IDLE;
         cmd       <= CMD_SET_ADDR;
         bit_cnt   <= 3'd0;
         rx_shift  <= 7'd0;
         ptr       <= 8'h00;
         have_addr <= 1'b0;
         rd_arm    <= 1'b0;
         tx_shift  <= 7'd0;
         tx_cnt    <= 3'd0;
         sdo       <= 1'b0;
         sdo_oe    <= 1'b0;
         reg_wr    <= 1'b0;
         reg_addr  <= 8'h00;
         reg_wdata <= 8'h00;
         busy      <= 1'b0;
         frame_err <= 1'b0;
         for (int i = 0; i < 256; i++) regs[i] <= REG_INIT;
      end else begin
         reg_wr    <= 1'b0;
         frame_err <= 1'b0;
         busy      <= ~ncs_s;
         // nCS rise has priority: a coincident sclk rise is dropped.
         if (ncs_rise) begin
            if (state != S_IDLE && bit_cnt != 3'd0) frame_err <= 1'b1;
            state   <= S_IDLE;
            bit_cnt <= 3'd0;
            rd_arm  <= 1'b0;
            sdo     <= 1'b0;
            sdo_oe  <= 1'b0;
         end else if (ncs_fall) begin
            state     <= S_CMD;
            bit_cnt   <= 3'd0;
            have_addr <= 1'b0;
            rd_arm    <= 1'b0;
         end else if (state != S_IDLE) begin
            if (sclk_rise) begin
               rx_shift <= rx_byte[6:0];
               bit_cnt  <= bit_cnt + 3'd1;
               if (byte_done) begin
                  case (state)
                     S_CMD: begin
                        cmd <= rx_byte[7:5];
                        case (rx_byte[7:5])
                           CMD_SET_ADDR, CMD_WRITE, CMD_WRITE_INC: state <= S_ARG;
                           CMD_READ, CMD_READ_INC: begin
                              state  <= S_ARG;
                              rd_arm <= 1'b1;
                           end
                           CMD_BURST: state <= S_BURST;
                           default: begin
                              state     <= S_IGNORE;
                              frame_err <= 1'b1;
                           end
                        endcase
                     end
                     S_ARG: begin
                        state <= S_IGNORE;
                        case (cmd)
                           CMD_SET_ADDR: ptr <= rx_byte;
                           CMD_WRITE, CMD_WRITE_INC: begin
                              regs[ptr] <= rx_byte;
                              reg_wr    <= 1'b1;
                              reg_addr  <= ptr;
                              reg_wdata <= rx_byte;
                              if (cmd == CMD_WRITE_INC) ptr <= ptr + 8'd1;
                           end
                           CMD_READ_INC: ptr <= ptr + 8'd1;
                           default: ;
                        endcase
                     end
                     S_BURST: begin
                        if (!have_addr) begin
                           ptr       <= rx_byte;
                           have_addr <= 1'b1;
                        end else begin
                           regs[ptr] <= rx_byte;
                           reg_wr    <= 1'b1;
                           reg_addr  <= ptr;
                           reg_wdata <= rx_byte;
                           ptr       <= ptr + 8'd1;
                        end
                     end
                     default: ;
                  endcase
               end
            end else if (sclk_fall) begin
               // Read data is shifted independently of state so the tail of
               // the data byte still drains after the FSM moves to IGNORE.
               if (rd_arm) begin
                  rd_arm   <= 1'b0;
                  tx_shift <= regs[ptr][6:0];
                  sdo      <= regs[ptr][7];
                  sdo_oe   <= 1'b1;
                  tx_cnt   <= 3'd0;
               end else if (sdo_oe) begin
                  if (tx_cnt == 3'd7) begin
                     sdo_oe <= 1'b0;
                     sdo    <= 1'b0;
                  end else begin
                     sdo      <= tx_shift[6];
                     tx_shift <= {tx_shift[5:0], 1'b0};
                     tx_cnt   <= tx_cnt + 3'd1;
                  end
               end
            end
         end
      end
   end

endmodule
